// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU arithmetic group: the serial
//            subtractor state encoding and a helper that sizes the chunk
//            counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Chunk-counter width: enough bits to index N/W chunks. A single-chunk
  // configuration still gets a 1-bit counter so the vector is never empty.
  function automatic int cnt_width(input int n, input int w);
    int chunks;
    chunks = n / w;
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk
// Purpose  : Combinational W-bit subtract slice: d = a - b - borrow_in.
//            Implemented as a + ~b + !borrow_in; the borrow out is the
//            inverted carry out.
// Ports    : a, b        - W-bit operand slices
//            borrow_in   - borrow from the previous (lower) slice
//            d           - W-bit difference slice
//            borrow_out  - borrow into the next (higher) slice
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] d,
  output logic         borrow_out
);

  logic [W:0] w_sum;

  always_comb begin
    w_sum      = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~borrow_in};
    d          = w_sum[W-1:0];
    borrow_out = ~w_sum[W];
  end

endmodule : sub_chunk
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Purpose  : Multi-cycle N-bit subtractor, diff = a - b - b_in. Processes W
//            bits per clock, LSB chunk first, with the borrow rippled between
//            chunks through a register. Start/done handshake; results hold
//            until the next accepted start.
// Ports    : clk, rst_n  - clock (rising edge), async active-low reset
//            start       - request, accepted when busy = 0
//            a, b, b_in  - operands, sampled on an accepted start
//            busy        - operation in progress
//            done        - one-cycle pulse when results are valid
//            diff        - a - b - b_in modulo 2^N
//            b_out       - unsigned borrow out (a < b + b_in)
//            overflow    - signed overflow of the subtract
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
  import alu_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         overflow
);

  localparam int              CW   = cnt_width(N, W);
  localparam logic [CW-1:0]   LAST = CW'(N / W - 1);

  generate
    if ((N % W) != 0 || W < 1) begin : g_bad_width
      $error("serial_sub: N must be a positive multiple of W");
    end
  endgenerate

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [N-1:0]  a_q,        a_d;
  logic [N-1:0]  b_q,        b_d;
  logic          borrow_q,   borrow_d;
  logic [N-1:0]  diff_q,     diff_d;
  logic          b_out_q,    b_out_d;
  logic          overflow_q, overflow_d;

  logic [W-1:0]  chunk_a;
  logic [W-1:0]  chunk_b;
  logic [W-1:0]  chunk_d;
  logic          chunk_borrow;

  assign chunk_a = a_q[cnt_q * W +: W];
  assign chunk_b = b_q[cnt_q * W +: W];

  sub_chunk #(.W(W)) u_sub_chunk (
    .a          (chunk_a),
    .b          (chunk_b),
    .borrow_in  (borrow_q),
    .d          (chunk_d),
    .borrow_out (chunk_borrow)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    borrow_d   = borrow_q;
    diff_d     = diff_q;
    b_out_d    = b_out_q;
    overflow_d = overflow_q;

    case (state_q)
      // DONE accepts a new start too, giving back-to-back operation.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_BUSY;
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        diff_d[cnt_q * W +: W] = chunk_d;
        borrow_d               = chunk_borrow;
        if (cnt_q == LAST) begin
          state_d    = ST_DONE;
          cnt_d      = '0;
          b_out_d    = chunk_borrow;
          // chunk_d[W-1] is the final diff MSB being written this cycle.
          overflow_d = (a_q[N-1] != b_q[N-1]) && (chunk_d[W-1] != a_q[N-1]);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      borrow_q   <= 1'b0;
      diff_q     <= '0;
      b_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      borrow_q   <= borrow_d;
      diff_q     <= diff_d;
      b_out_q    <= b_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign done     = (state_q == ST_DONE);
  assign diff     = diff_q;
  assign b_out    = b_out_q;
  assign overflow = overflow_q;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Purpose  : Self-checking bench for serial_sub (N=64, W=8): a table of
//            directed vectors plus hand-written handshake and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  localparam int N   = 64;
  localparam int W   = 8;
  localparam int LAT = N / W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
  logic         overflow;

  int checks;
  int errors;

  serial_sub #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .b_out    (b_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the operand inputs after acceptance,
  // then check busy length, the done pulse and the results.
  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    a     = v.a;
    b     = v.b;
    b_in  = v.bin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    b_in  = 1'b1;
    cyc   = 0;
    while (busy && cyc < 4 * LAT) begin
      chk($sformatf("v%0d done-during-busy", idx), {63'd0, done}, 64'd0);
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy-cycles", idx), 64'(cyc), 64'(LAT));
    chk($sformatf("v%0d done", idx), {63'd0, done}, 64'd1);
    chk($sformatf("v%0d diff", idx), diff, v.exp_diff);
    chk($sformatf("v%0d b_out", idx), {63'd0, b_out}, {63'd0, v.exp_bout});
    chk($sformatf("v%0d overflow", idx), {63'd0, overflow}, {63'd0, v.exp_ovf});
    @(negedge clk);
    chk($sformatf("v%0d done-one-cycle", idx), {63'd0, done}, 64'd0);
    chk($sformatf("v%0d diff-hold", idx), diff, v.exp_diff);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    b_in   = 1'b0;

    //            a                      b                      bin  diff                   bout ovf
    vecs[0] = '{64'h0,                 64'h0,                 1'b0, 64'h0,                 1'b0, 1'b0};
    vecs[1] = '{64'h1,                 64'h0,                 1'b0, 64'h1,                 1'b0, 1'b0};
    vecs[2] = '{64'h0,                 64'h1,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1,               1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[5] = '{64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{64'h0101_0101_0101_0101, 64'h0010_1010_1010_1011, 1'b0, 64'h00F0_F0F0_F0F0_F0F0, 1'b0, 1'b0};
    vecs[7] = '{64'd10,                64'd3,                 1'b1, 64'd6,                 1'b0, 1'b0};
    vecs[8] = '{64'h0000_0100_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_00FF_FFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst busy",     {63'd0, busy},     64'd0);
    chk("rst done",     {63'd0, done},     64'd0);
    chk("rst diff",     diff,              64'd0);
    chk("rst b_out",    {63'd0, b_out},    64'd0);
    chk("rst overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], i);

    // start held high with changing operands; mid-BUSY starts ignored,
    // DONE-cycle start accepted with no idle gap.
    @(negedge clk);
    start = 1'b1;
    a     = 64'd100;
    b     = 64'd1;
    b_in  = 1'b0;
    for (int op = 0; op < 2; op++) begin
      for (int c = 0; c < LAT; c++) begin
        @(negedge clk);
        chk($sformatf("b2b%0d busy c%0d", op, c), {63'd0, busy}, 64'd1);
        a    = {$urandom, $urandom};
        b    = {$urandom, $urandom};
        b_in = 1'($urandom);
      end
      @(negedge clk);
      chk($sformatf("b2b%0d done", op), {63'd0, done}, 64'd1);
      chk($sformatf("b2b%0d diff", op), diff, (op == 0) ? 64'd99 : 64'd43);
      a    = 64'd50;
      b    = 64'd7;
      b_in = 1'b0;
      if (op == 1) start = 1'b0;
    end
    @(negedge clk);
    chk("b2b idle after", {63'd0, busy | done}, 64'd0);

    // Reset asserted mid-operation
    @(negedge clk);
    a     = 64'hDEAD_BEEF_0000_1234;
    b     = 64'h1;
    b_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy",     {63'd0, busy},     64'd0);
    chk("abort done",     {63'd0, done},     64'd0);
    chk("abort diff",     diff,              64'd0);
    chk("abort b_out",    {63'd0, b_out},    64'd0);
    chk("abort overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (2 * LAT) begin
        @(negedge clk);
        seen = seen | done | busy;
      end
      chk("abort no done", {63'd0, seen}, 64'd0);
    end
    begin
      vec_t v53;
      v53 = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
      run_op(v53, 99);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_serial_sub
`default_nettype wire

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Multi-cycle N-bit subtractor: diff = a - b - b_in. Processes W bits per clock, LSB chunk first, rippling the borrow between chunks in a register.
- Counterpart to the combinational ADD block in the ALU arithmetic group. Used where a full-width single-cycle subtract path is too costly.
- Start/done handshake; results stay stable until the next accepted start.

Parameters:
- N, 64, operand and result width in bits.
- W, 8, bits processed per cycle. N must be a multiple of W; elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- a  input  N  minuend, sampled on accepted start.
- b  input  N  subtrahend, sampled on accepted start.
- b_in  input  1  borrow in, sampled on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- diff  output  N  a - b - b_in, modulo 2^N.
- b_out  output  1  unsigned borrow out: 1 iff a < b + b_in.
- overflow  output  1  signed (two's-complement) overflow of the subtract.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; busy=0, done=0, diff=0, b_out=0, overflow=0; chunk counter and operand registers cleared.
- States:
  - IDLE: on start, latch a, b, b_in; go to BUSY.
  - BUSY: one chunk per cycle, processing bit slice [k*W +: W] for k = 0 .. N/W-1.
  - DONE: lasts one cycle, then IDLE.
- Chunk arithmetic:
  - {c, d} = a_k + ~b_k + !borrow, where c is the carry out.
  - d is written into diff chunk k; borrow becomes !c.
  - Initial borrow is b_in.
- Latency: start accepted at edge T; busy=1 from T to T+N/W; done=1 during the cycle after edge T+N/W.
  - Full diff, b_out and overflow are valid when done is high and hold until the next accepted start.
  - busy=0 in DONE.
- Final flags:
  - b_out = borrow after the last chunk.
  - overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]). b_in does not enter the overflow formula except through diff.
- start while busy=1: ignored; the in-flight operation and its operands are unaffected.
- start during DONE cycle: accepted (back-to-back operation). done still pulses for the finishing operation; diff is overwritten chunk by chunk from the next cycle.
- diff during BUSY: partially updated and not valid; consumers use done.
- Operand changes after acceptance: no effect.
- rst_n asserted mid-operation: abort immediately; all outputs return to reset values; no done pulse.
- N/W = 1: single BUSY cycle; same handshake.

Decomposition:
- Shared package alu_pkg:
  - state encoding (IDLE, BUSY, DONE) as a typedef enum;
  - a localparam function computing chunk-counter width, $clog2(N/W) with a minimum of 1.
- Sub-module sub_chunk: combinational W-bit a - b - borrow_in, outputs d[W-1:0] and borrow_out. It is the only arithmetic in the block.

Test Plan (N=64, W=8, latency 8):
- Reset release, then a=0, b=0, b_in=0, start -> busy high 8 cycles; done pulses once; diff=0, b_out=0, overflow=0.
- a=1, b=0 -> diff=64'h1, b_out=0. Then a=0, b=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, b_out=1, overflow=0.
- a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, b_out=0, overflow=1. Then a=64'h7FFF_FFFF_FFFF_FFFF, b=64'hFFFF_FFFF_FFFF_FFFF -> diff=64'h8000_0000_0000_0000, b_out=1, overflow=1.
- a=b=64'h1111_1111_1111_1111, b_in=1 -> diff=all F, b_out=1. Also a=64'h0101_0101_0101_0101, b=64'h0010_1010_1010_1011 -> diff=64'h00F0_F0F0_F0F0_F0F0, b_out=0.
- start held high throughout with changing operands -> only the operand at each acceptance is used. start pulses mid-BUSY are ignored; start in the DONE cycle begins the next operation with no idle gap.
- rst_n low at cycle 4 of an operation -> outputs 0 immediately, no done pulse. A following operation 5-3 -> diff=2, correct.
